// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC channel sequencer: state encoding, channel
// geometry and the result substituted for an abandoned conversion.
package adc_seq_pkg;

  localparam int NUM_CHAN = 32;
  localparam int CHAN_W   = $clog2(NUM_CHAN);
  localparam int DATA_W   = 12;

  localparam logic [DATA_W-1:0] TMO_FILL = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    START,
    WAIT,
    EMIT,
    NEXT
  } state_t;

  // Width of a counter that must hold 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chan_pick.sv
// Combinational channel finder: the lowest enabled channel, and the lowest
// enabled channel strictly above the current one.
module chan_pick
  import adc_seq_pkg::*;
(
  input  logic [NUM_CHAN-1:0] mask,
  input  logic [CHAN_W-1:0]   cur,
  output logic                next_above_valid,
  output logic [CHAN_W-1:0]   next_above,
  output logic [CHAN_W-1:0]   lowest_set
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    next_above_valid = 1'b0;
    next_above       = '0;
    lowest_set       = '0;
    // Scan downwards so the last hit recorded is the lowest qualifying bit.
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_set = CHAN_W'(i);
        if (CHAN_W'(i) > cur) begin
          next_above_valid = 1'b1;
          next_above       = CHAN_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Steps the ADC through the enabled monitor channels in ascending order,
// with settle time, optional averaging and conversion timeout.
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 64,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                seq_en,
  input  logic [NUM_CHAN-1:0] chan_mask,
  output logic [CHAN_W-1:0]   adc_chnum,
  output logic                adc_start,
  input  logic                adc_dataval,
  input  logic [DATA_W-1:0]   adc_data,
  output logic [DATA_W-1:0]   adc_result,
  output logic [CHAN_W-1:0]   adc_channel,
  output logic                adc_strb,
  output logic [7:0]          timeout_cnt,
  output logic                seq_busy
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int SET_W = cnt_width(SETTLE_CYCLES);
  localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] SAMP_TARGET = CNT_W'(1 << AVG_LOG2);
  // Shifted fill so that the averaging shift in EMIT yields exactly TMO_FILL.
  localparam logic [ACC_W-1:0] FILL_ACC    = ACC_W'(TMO_FILL) << AVG_LOG2;

  state_t              state;
  logic [NUM_CHAN-1:0] round_mask;
  logic [CHAN_W-1:0]   cur_chan;
  logic [SET_W-1:0]    settle_cnt;
  logic [TMO_W-1:0]    tmo_timer;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    samp_cnt;
  logic                nxt_valid;
  logic [CHAN_W-1:0]   nxt_chan;

  logic [NUM_CHAN-1:0] pick_mask;
  logic                next_above_valid;
  logic [CHAN_W-1:0]   next_above;
  logic [CHAN_W-1:0]   lowest_set;
  logic                settle_done;
  logic                tmo_done;
  logic [CNT_W-1:0]    samp_next;

  // EMIT looks ahead within the latched round; IDLE and NEXT need the lowest
  // bit of the live mask for a fresh round, so one finder serves both.
  assign pick_mask = (state == EMIT) ? round_mask : chan_mask;

  chan_pick u_chan_pick (
    .mask             (pick_mask),
    .cur              (cur_chan),
    .next_above_valid (next_above_valid),
    .next_above       (next_above),
    .lowest_set       (lowest_set)
  );

  assign settle_done = (SETTLE_CYCLES <= 1) || (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
  assign tmo_done    = (TIMEOUT_CYCLES <= 1) || (tmo_timer == TMO_W'(TIMEOUT_CYCLES - 1));
  assign samp_next   = samp_cnt + CNT_W'(1);
  assign adc_chnum   = cur_chan;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state       <= IDLE;
      round_mask  <= '0;
      cur_chan    <= '0;
      settle_cnt  <= '0;
      tmo_timer   <= '0;
      acc         <= '0;
      samp_cnt    <= '0;
      nxt_valid   <= 1'b0;
      nxt_chan    <= '0;
      adc_start   <= 1'b0;
      adc_result  <= '0;
      adc_channel <= '0;
      adc_strb    <= 1'b0;
      timeout_cnt <= '0;
      seq_busy    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample pre-edge values, independent of statement order.
      adc_start <= 1'b0;
      adc_strb  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (seq_en && (chan_mask != '0)) begin
            round_mask <= chan_mask;
            cur_chan   <= lowest_set;
            settle_cnt <= '0;
            seq_busy   <= 1'b1;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          if (settle_done) begin
            adc_start <= 1'b1;
            state     <= START;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end

        START: begin
          tmo_timer <= '0;
          state     <= WAIT;
        end

        WAIT: begin
          if (adc_dataval) begin
            acc      <= acc + ACC_W'(adc_data);
            samp_cnt <= samp_next;
            if (samp_next == SAMP_TARGET) begin
              state <= EMIT;
            end else begin
              // Back-to-back conversions on the same channel need no re-settle.
              adc_start <= 1'b1;
              state     <= START;
            end
          end else if (tmo_done) begin
            acc <= FILL_ACC;
            if (timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
            state <= EMIT;
          end else begin
            tmo_timer <= tmo_timer + TMO_W'(1);
          end
        end

        EMIT: begin
          adc_result  <= DATA_W'(acc >> AVG_LOG2);
          adc_channel <= cur_chan;
          adc_strb    <= 1'b1;
          acc         <= '0;
          samp_cnt    <= '0;
          nxt_valid   <= next_above_valid;
          nxt_chan    <= next_above;
          state       <= NEXT;
        end

        NEXT: begin
          if (!seq_en) begin
            seq_busy <= 1'b0;
            state    <= IDLE;
          end else if (nxt_valid) begin
            cur_chan   <= nxt_chan;
            settle_cnt <= '0;
            state      <= SETTLE;
          end else begin
            // Round wrap: the live mask only takes effect here.
            round_mask <= chan_mask;
            if (chan_mask == '0) begin
              seq_busy <= 1'b0;
              state    <= IDLE;
            end else begin
              cur_chan   <= lowest_set;
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end
        end

        default: begin
          seq_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// Scoreboard bench for adc_sequencer: stimulus queues the expected strobes,
// an ADC model answers conversions, and a monitor checks every strobe.
module tb_adc_sequencer;

  localparam int SETTLE = 16;
  localparam int AVG    = 2;
  localparam int TMO    = 60;
  localparam int NSAMP  = 1 << AVG;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seq_en = 1'b0;
  logic [31:0] chan_mask = '0;
  logic        adc_dataval = 1'b0;
  logic [11:0] adc_data = '0;
  logic [4:0]  adc_chnum;
  logic        adc_start;
  logic [11:0] adc_result;
  logic [4:0]  adc_channel;
  logic        adc_strb;
  logic [7:0]  timeout_cnt;
  logic        seq_busy;

  adc_sequencer #(
    .SETTLE_CYCLES  (SETTLE),
    .AVG_LOG2       (AVG),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .seq_en      (seq_en),
    .chan_mask   (chan_mask),
    .adc_chnum   (adc_chnum),
    .adc_start   (adc_start),
    .adc_dataval (adc_dataval),
    .adc_data    (adc_data),
    .adc_result  (adc_result),
    .adc_channel (adc_channel),
    .adc_strb    (adc_strb),
    .timeout_cnt (timeout_cnt),
    .seq_busy    (seq_busy)
  );

  typedef struct {
    int ch;
    int res;
    bit tmo;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lut[32][NSAMP];
  int          conv_idx[32];
  logic [31:0] dead = '0;
  bit          spur_en = 1'b1;
  int          exp_tmo = 0;
  longint      cyc = 0;
  longint      last_strb = -1;
  longint      last_start = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d strobes still pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // Reference: the average of the NSAMP values the ADC hands out for a channel,
  // or the fill value when that channel never answers.
  function automatic int exp_val(input int ch);
    int s = 0;
    if (dead[ch]) return 'hFFF;
    for (int k = 0; k < NSAMP; k++) s += lut[ch][k];
    return s / NSAMP;
  endfunction

  task automatic push_round(input logic [31:0] m, input int rounds);
    for (int r = 0; r < rounds; r++)
      for (int ch = 0; ch < 32; ch++)
        if (m[ch]) exp_q.push_back('{ch, exp_val(ch), dead[ch]});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d strobes still pending, expected 0 after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (seq_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("seq_busy_idle", 32'(seq_busy), 0);
  endtask

  task automatic wait_chan(input int ch, input bit need_start);
    int n = 0;
    while (!(seq_busy && int'(adc_chnum) == ch && (adc_start || !need_start)) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_chan: got chnum %0d, expected %0d within 5000 cycles", adc_chnum, ch);
    end
    #1;
  endtask

  task automatic run_rounds(input logic [31:0] m, input int rounds);
    push_round(m, rounds);
    chan_mask = m;
    seq_en    = 1'b1;
    wait_drain(exp_q.size() * 200 + 200);
    seq_en = 1'b0;
    wait_idle();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_chnum"},   32'(adc_chnum),   0);
    check({tag, "_start"},   32'(adc_start),   0);
    check({tag, "_result"},  32'(adc_result),  0);
    check({tag, "_channel"}, 32'(adc_channel), 0);
    check({tag, "_strb"},    32'(adc_strb),    0);
    check({tag, "_tmo_cnt"}, 32'(timeout_cnt), 0);
    check({tag, "_busy"},    32'(seq_busy),    0);
  endtask

  // ADC model: answers each start pulse after 1..6 cycles; may also raise a
  // garbage pulse in the start cycle, which the sequencer must ignore.
  initial begin
    int ch;
    int d;
    forever begin
      @(negedge clk);
      adc_dataval = 1'b0;
      while (adc_start && rst_n) begin
        ch = int'(adc_chnum);
        if (dead[ch]) begin
          @(negedge clk);
        end else begin
          d = int'($urandom_range(1, 6));
          if (spur_en && $urandom_range(0, 3) == 0) begin
            adc_dataval = 1'b1;
            adc_data    = 12'($urandom);
          end
          repeat (d) @(negedge clk) adc_dataval = 1'b0;
          if (rst_n) begin
            adc_dataval  = 1'b1;
            adc_data     = 12'(lut[ch][conv_idx[ch]]);
            conv_idx[ch] = (conv_idx[ch] + 1) % NSAMP;
          end
          @(negedge clk);
          adc_dataval = 1'b0;
        end
      end
    end
  end

  // Monitor: pops one expectation per strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (adc_start) last_start = cyc;
      if (adc_strb) begin
        if (last_strb >= 0) check_range("strobe_spacing", cyc - last_strb, SETTLE + 4, 64'd1 << 40);
        last_strb = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got channel %0d result %0h, expected no strobe", adc_channel, adc_result);
        end else begin
          e = exp_q.pop_front();
          check("channel", 32'(adc_channel), e.ch);
          check("result", 32'(adc_result), e.res);
          if (e.tmo) begin
            exp_tmo = (exp_tmo < 255) ? exp_tmo + 1 : 255;
            check_range("timeout_latency", cyc - last_start, TMO, TMO + 3);
          end
          check("timeout_cnt", 32'(timeout_cnt), exp_tmo);
        end
      end
    end
  end

  initial begin
    logic [31:0] m;
    for (int ch = 0; ch < 32; ch++) begin
      conv_idx[ch] = 0;
      for (int k = 0; k < NSAMP; k++) lut[ch][k] = 'h100 + ch;
    end

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    // Channels 0,1,4 repeating with 0x100+channel.
    run_rounds(32'h0000_0013, 3);

    // Averaging: 10,11,12,13 on channel 3 gives 11.
    for (int k = 0; k < NSAMP; k++) lut[3][k] = 10 + k;
    run_rounds(32'h0000_0008, 1);

    // Random masks and data, then a lone channel that simply repeats.
    for (int t = 0; t < 4; t++) begin
      for (int ch = 0; ch < 32; ch++)
        for (int k = 0; k < NSAMP; k++) lut[ch][k] = int'($urandom_range(0, 4095));
      m = ($urandom & $urandom & $urandom) | (32'd1 << $urandom_range(0, 31));
      run_rounds(m, 2);
    end
    run_rounds(32'h0002_0000, 3);

    // Timeouts: channel 2 never answers, order continues with channel 0.
    dead = 32'h0000_0004;
    run_rounds(32'h0000_0007, 2);
    check("tmo_after_two", 32'(timeout_cnt), 2);
    run_rounds(32'h0000_0004, 298);
    check("tmo_saturated", 32'(timeout_cnt), 255);
    dead = '0;

    // Mask change mid-round, then an empty mask at the wrap.
    push_round(32'h0000_0003, 1);
    push_round(32'h0000_000C, 1);
    chan_mask = 32'h0000_0003;
    seq_en    = 1'b1;
    wait_chan(0, 1'b0);
    chan_mask = 32'h0000_000C;
    wait_chan(3, 1'b0);
    chan_mask = '0;
    wait_drain(2000);
    wait_idle();
    seq_en = 1'b0;

    // Enable dropped while channel 5 converts: it still completes once.
    exp_q.push_back('{5, exp_val(5), 1'b0});
    chan_mask = 32'h0000_0120;
    seq_en    = 1'b1;
    wait_chan(5, 1'b1);
    seq_en = 1'b0;
    wait_drain(2000);
    wait_idle();

    // Reset in the middle of SETTLE.
    chan_mask = 32'h0000_0030;
    seq_en    = 1'b1;
    wait_chan(4, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_tmo = 0;
    #1;
    check_outputs_zero("midreset");
    seq_en = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_busy", 32'(seq_busy), 0);
    #1;
    run_rounds(32'h0000_0030, 1);

    repeat (30) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
